// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the ALU function codes the trial subtractor uses.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Matches the ALU funct field so the trial subtraction can share that unit.
    localparam logic [5:0] ALU_FUNCT_ADD = 6'h20;
    localparam logic [5:0] ALU_FUNCT_SUB = 6'h22;

endpackage

// File: rtl/div_control.sv
// Divider sequencer: IDLE/DIV/DONE FSM and iteration counter. It emits the
// load and shift strobes for the datapath in seq_divider.
module div_control
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic divisor_zero,
    output logic load,
    output logic shift_en,
    output logic ready,
    output logic busy,
    output logic dz_set
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        dz_set     = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                ready = (state_reg == DONE);
                if (run) begin
                    load       = 1'b1;
                    count_next = '0;
                    dz_set     = divisor_zero;
                    // A zero divisor skips the iterations entirely.
                    state_next = divisor_zero ? DONE : DIV;
                end
            end
            DIV: begin
                busy       = 1'b1;
                shift_en   = 1'b1;
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// shared subtract path; quotient and remainder held while ready is high.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Dividend_input,
    input  logic [WIDTH-1:0] Divisor_input,
    input  logic             run,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Quotient_output,
    output logic [WIDTH-1:0] Remainder_output
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Stand-in for the shared ALU adder/subtractor.
    function automatic logic [WIDTH:0] alu_addsub(input logic [5:0] funct,
                                                  input logic [WIDTH:0] a,
                                                  input logic [WIDTH:0] b);
        return (funct == ALU_FUNCT_SUB) ? (a - b) : (a + b);
    endfunction

    logic [2*WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic               dz_reg;

    logic               load;
    logic               shift_en;
    logic               dz_set;
    logic               divisor_zero;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;

    assign divisor_zero = (Divisor_input == '0);

    div_control #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_control (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .divisor_zero (divisor_zero),
        .load         (load),
        .shift_en     (shift_en),
        .ready        (ready),
        .busy         (busy),
        .dz_set       (dz_set)
    );

    assign shifted = rem_reg << 1;
    assign trial   = alu_addsub(ALU_FUNCT_SUB, {1'b0, shifted[2*WIDTH-1:WIDTH]},
                                {1'b0, divisor_reg});

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg     <= '0;
            divisor_reg <= '0;
            dz_reg      <= 1'b0;
        end else if (load) begin
            divisor_reg <= Divisor_input;
            dz_reg      <= dz_set;
            // Divide by zero lands directly on the final result: Q = all ones, R = dividend.
            rem_reg     <= dz_set ? {Dividend_input, {WIDTH{1'b1}}}
                                  : {{WIDTH{1'b0}}, Dividend_input};
        end else if (shift_en) begin
            if (!trial[WIDTH]) begin
                rem_reg <= {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                rem_reg <= shifted;
            end
        end
    end

    assign div_by_zero      = dz_reg;
    assign Quotient_output  = rem_reg[WIDTH-1:0];
    assign Remainder_output = rem_reg[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, hand-written corner
// sequences (mid-run run pulses, reset) and randomized vectors vs / and %.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        bit          glitch;
    } vec_t;

    vec_t vecs[10];

    seq_divider #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .Dividend_input   (dividend),
        .Divisor_input    (divisor),
        .run              (run),
        .ready            (ready),
        .busy             (busy),
        .div_by_zero      (div_by_zero),
        .Quotient_output  (quotient),
        .Remainder_output (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of division.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        if (b == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Entered and left at posedge+1. Issues run, follows the transaction to
    // ready and checks latency, busy duration, result and flag.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q_exp, input logic [31:0] r_exp,
                           input logic dz_exp, input bit glitch, input string tag);
        int lat;
        int busy_cnt;
        int both;
        int exp_lat;
        dividend = a;
        divisor  = b;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run      = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check({tag, " ready_after_load"}, 32'(ready), 32'(dz_exp));
        check({tag, " dz_after_load"}, 32'(div_by_zero), 32'(dz_exp));
        lat      = 0;
        busy_cnt = int'(busy);
        both     = 0;
        while (!ready && lat < 40) begin
            if (glitch && (lat == 4 || lat == 19)) begin
                run      = 1'b1;
                dividend = $urandom;
                divisor  = $urandom_range(1, 50);
            end else begin
                run = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (busy && ready) both++;
        end
        run     = 1'b0;
        exp_lat = dz_exp ? 0 : 32;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " ready_busy_overlap"}, 32'(both), 32'd0);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " quotient"}, quotient, q_exp);
        check({tag, " remainder"}, remainder, r_exp);
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(dz_exp));
        $display("%s: %0d / %0d -> Q=%0d R=%0d dz=%0b lat=%0d", tag, a, b,
                 quotient, remainder, div_by_zero, lat);
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rdz;
        int          sel;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0, 1'b0};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,  1'b0, 1'b0};
        vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1, 1'b0};
        vecs[5] = '{32'd9,          32'd3,          32'd3,          32'd0,  1'b0, 1'b0};
        vecs[6] = '{32'd1000,       32'd9,          32'd111,        32'd1,  1'b0, 1'b1};
        vecs[7] = '{32'd81,         32'd9,          32'd9,          32'd0,  1'b0, 1'b0};
        vecs[8] = '{32'd0,          32'd5,          32'd0,          32'd0,  1'b0, 1'b0};
        vecs[9] = '{32'h8000_0001,  32'h8000_0000,  32'd1,          32'd1,  1'b0, 1'b0};

        rst      = 1'b1;
        run      = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ready", 32'(ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dz", 32'(div_by_zero), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        $display("reset: ready=%0b busy=%0b Q=%0h R=%0h", ready, busy, quotient, remainder);

        // Consecutive entries start in the first DONE cycle of the previous one.
        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                    vecs[i].glitch, $sformatf("vec%0d", i));
        end

        // DONE holds indefinitely without run.
        repeat (5) @(posedge clk);
        #1;
        check("hold ready", 32'(ready), 32'd1);
        check("hold quotient", quotient, 32'd1);
        check("hold remainder", remainder, 32'd1);
        $display("hold: ready=%0b Q=%0d R=%0d", ready, quotient, remainder);

        // Reset sampled on edge 10 of a division abandons it.
        dividend = 32'd1234;
        divisor  = 32'd7;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun reset ready", 32'(ready), 32'd0);
        check("midrun reset busy", 32'(busy), 32'd0);
        check("midrun reset dz", 32'(div_by_zero), 32'd0);
        check("midrun reset quotient", quotient, 32'd0);
        check("midrun reset remainder", remainder, 32'd0);
        $display("midrun reset: ready=%0b busy=%0b Q=%0h R=%0h", ready, busy, quotient, remainder);

        // Reset and run together: reset wins and the run is lost.
        rst      = 1'b1;
        run      = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #1;
        check("rst+run ready", 32'(ready), 32'd0);
        check("rst+run busy", 32'(busy), 32'd0);
        check("rst+run dz", 32'(div_by_zero), 32'd0);
        $display("rst+run: ready=%0b busy=%0b dz=%0b", ready, busy, div_by_zero);
        run_div(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 1'b0, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rb = 32'd0;
                1, 2, 3: rb = $urandom_range(1, 255);
                4:       rb = $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (sel == 9) ra = ra >> $urandom_range(0, 31);
            model(ra, rb, rq, rr, rdz);
            run_div(ra, rb, rq, rr, rdz, 1'b0, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
